// File: rtl/mist_frame_pkg.sv
// Shared types for the MiST frame counter: FSM state encoding and default counter width.
package mist_frame_pkg;

  localparam int unsigned DefaultCw = 32;

  typedef enum logic [1:0] {
    StHold,
    StSettle,
    StRun
  } state_e;

endpackage

// File: rtl/mist_vs_qual.sv
// Vertical-sync falling-edge qualifier: an edge counts only after VS_MIN consecutive high cycles.
module mist_vs_qual #(
  parameter int unsigned VS_MIN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic vs,
  output logic qe
);

  localparam int unsigned HW = (VS_MIN < 1) ? 1 : $clog2(VS_MIN + 1);
  localparam logic [HW-1:0] HiMax = HW'(VS_MIN);

  logic [HW-1:0] hi_cnt_q, hi_cnt_d;
  logic          vs_dly_q;

  // Saturating run length of vs-high samples; any low sample restarts it.
  always_comb begin
    hi_cnt_d = '0;
    if (vs) begin
      hi_cnt_d = (hi_cnt_q == HiMax) ? hi_cnt_q : hi_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_cnt_q <= '0;
      vs_dly_q <= 1'b0;
    end else begin
      hi_cnt_q <= hi_cnt_d;
      vs_dly_q <= vs;
    end
  end

  assign qe = vs_dly_q & ~vs & (hi_cnt_q == HiMax);

endmodule

// File: rtl/mist_frame_cnt.sv
// Frame counter for the test-bench dump controller, gated on ROM download.
// Optional dump window strobes are compiled in with MIST_FRAME_DUMP_WINDOW_EN.
module mist_frame_cnt
  import mist_frame_pkg::*;
#(
  parameter int unsigned CW            = DefaultCw,
  parameter int unsigned VS_MIN        = 4,
  parameter int unsigned SETTLE_FRAMES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vs,
  input  logic          downloading,
  input  logic [CW-1:0] dump_start,
  input  logic [CW-1:0] dump_stop,
  output logic [CW-1:0] frame_cnt,
  output logic          frame_tick,
  output logic          running,
  output logic          dump_trig,
  output logic          dump_on
);

  localparam int unsigned SW = (SETTLE_FRAMES < 1) ? 1 : $clog2(SETTLE_FRAMES + 1);
  localparam logic [SW-1:0] SettleInit = SW'(SETTLE_FRAMES);

  logic qe;

  state_e        state_q, state_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          tick_q, tick_d;
  logic          running_q, running_d;
  logic          trig_q, trig_d;
  logic          on_q, on_d;

  mist_vs_qual #(
    .VS_MIN (VS_MIN)
  ) u_vs_qual (
    .clk (clk),
    .rst (rst),
    .vs  (vs),
    .qe  (qe)
  );

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    cnt_d        = cnt_q;
    cnt_inc      = cnt_q + 1'b1;
    tick_d       = 1'b0;
    trig_d       = 1'b0;
    on_d         = on_q;

    // Download wins over any edge seen in the same cycle.
    if (downloading) begin
      state_d = StHold;
      cnt_d   = '0;
      on_d    = 1'b0;
    end else begin
      unique case (state_q)
        StHold: begin
          cnt_d = '0;
          on_d  = 1'b0;
          if (SETTLE_FRAMES == 0) begin
            state_d = StRun;
          end else begin
            state_d      = StSettle;
            settle_cnt_d = SettleInit;
          end
        end
        StSettle: begin
          if (qe) begin
            settle_cnt_d = settle_cnt_q - 1'b1;
            if (settle_cnt_q == SW'(1)) begin
              state_d = StRun;
            end
          end
        end
        StRun: begin
          if (qe) begin
            cnt_d  = cnt_inc;
            tick_d = 1'b1;
`ifdef MIST_FRAME_DUMP_WINDOW_EN
            // Start takes priority so an empty window still triggers once.
            if (cnt_inc == dump_start) begin
              trig_d = 1'b1;
              on_d   = (dump_start != dump_stop);
            end else if (cnt_inc == dump_stop) begin
              on_d = 1'b0;
            end
`endif
          end
        end
        default: state_d = StHold;
      endcase
    end

    running_d = (state_d == StRun);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StHold;
      settle_cnt_q <= '0;
      cnt_q        <= '0;
      tick_q       <= 1'b0;
      running_q    <= 1'b0;
      trig_q       <= 1'b0;
      on_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      cnt_q        <= cnt_d;
      tick_q       <= tick_d;
      running_q    <= running_d;
      trig_q       <= trig_d;
      on_q         <= on_d;
    end
  end

`ifndef MIST_FRAME_DUMP_WINDOW_EN
  logic unused_dump_cfg;
  assign unused_dump_cfg = ^{dump_start, dump_stop};
`endif

  assign frame_cnt  = cnt_q;
  assign frame_tick = tick_q;
  assign running    = running_q;
  assign dump_trig  = trig_q;
  assign dump_on    = on_q;

endmodule
